// File: rtl/cpu_pkg.sv
// Shared CPU constants and register-file types; must match the register array.
package cpu_pkg;

    localparam int REG_NUM   = 32;
    localparam int REG_WIDTH = 32;
    localparam int ADDR_W    = 5;

    typedef logic [ADDR_W-1:0]    reg_addr_t;
    typedef logic [REG_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with hazard lookups for rs1, rs2 and rd.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int REG_NUM = cpu_pkg::REG_NUM,
    parameter int ADDR_W  = cpu_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en_i,
    input  logic [ADDR_W-1:0]  set_addr_i,
    input  logic               clr_en_i,
    input  logic [ADDR_W-1:0]  clr_addr_i,
    input  logic [ADDR_W-1:0]  rs1_i,
    input  logic [ADDR_W-1:0]  rs2_i,
    input  logic [ADDR_W-1:0]  rd_i,
    output logic               rs1_busy_o,
    output logic               rs2_busy_o,
    output logic               rd_busy_o,
    output logic [REG_NUM-1:0] busy_o
);

    logic [REG_NUM-1:0] busy_q, busy_d;

    // Set is applied after clear: a new writer issued in the same cycle as the
    // old writer retires must remain outstanding.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign rd_busy_o  = busy_q[rd_i];
    assign busy_o     = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-array read, writeback bypass, hazard stall and a
// single registered output slot toward execute.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int REG_NUM   = cpu_pkg::REG_NUM,
    parameter int REG_WIDTH = cpu_pkg::REG_WIDTH,
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int TAG_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_rs1,
    input  logic [ADDR_W-1:0]    in_rs2,
    input  logic [ADDR_W-1:0]    in_rd,
    input  logic                 in_rd_we,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [ADDR_W-1:0]    reg1_address,
    output logic [ADDR_W-1:0]    reg2_address,
    input  logic [REG_WIDTH-1:0] reg1,
    input  logic [REG_WIDTH-1:0] reg2,
    input  logic                 wb_word_enable,
    input  logic                 wb_byte_enable,
    input  logic [ADDR_W-1:0]    wb_address,
    input  logic [REG_WIDTH-1:0] wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_op1,
    output logic [REG_WIDTH-1:0] out_op2,
    output logic [ADDR_W-1:0]    out_rd,
    output logic                 out_rd_we,
    output logic [TAG_W-1:0]     out_tag,
    output logic [REG_NUM-1:0]   sb_busy
);

    logic                 wb_hit;
    logic                 rs1_busy, rs2_busy, rd_busy;
    logic                 rs1_blk, rs2_blk, rd_blk, hazard;
    logic                 accept;
    logic [REG_WIDTH-1:0] op1_byp, op2_byp;

    logic                 valid_q, valid_d;
    logic [REG_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [ADDR_W-1:0]    rd_q, rd_d;
    logic                 rd_we_q, rd_we_d;
    logic [TAG_W-1:0]     tag_q, tag_d;

    assign reg1_address = in_rs1;
    assign reg2_address = in_rs2;
    assign wb_hit       = wb_word_enable | wb_byte_enable;

    // Word write wins over byte write, as in the register array.
    always_comb begin
        op1_byp = reg1;
        if (wb_word_enable && wb_address == in_rs1)
            op1_byp = wb_data;
        else if (wb_byte_enable && wb_address == in_rs1)
            op1_byp = {reg1[REG_WIDTH-1:8], wb_data[7:0]};
    end

    always_comb begin
        op2_byp = reg2;
        if (wb_word_enable && wb_address == in_rs2)
            op2_byp = wb_data;
        else if (wb_byte_enable && wb_address == in_rs2)
            op2_byp = {reg2[REG_WIDTH-1:8], wb_data[7:0]};
    end

    reg_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (accept && in_rd_we),
        .set_addr_i (in_rd),
        .clr_en_i   (wb_hit),
        .clr_addr_i (wb_address),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .rd_i       (in_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .busy_o     (sb_busy)
    );

    // A pending register retiring this very cycle is not a hazard: sources
    // pick the value up through the bypass, and the WAW slot frees up.
    assign rs1_blk  = rs1_busy && !(wb_hit && wb_address == in_rs1);
    assign rs2_blk  = rs2_busy && !(wb_hit && wb_address == in_rs2);
    assign rd_blk   = in_rd_we && rd_busy && !(wb_hit && wb_address == in_rd);
    assign hazard   = rs1_blk || rs2_blk || rd_blk;

    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;
        tag_d   = tag_q;
        if (accept) begin
            valid_d = 1'b1;
            op1_d   = op1_byp;
            op2_d   = op2_byp;
            rd_d    = in_rd;
            rd_we_d = in_rd_we;
            tag_d   = in_tag;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            rd_we_q <= rd_we_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_rd    = rd_q;
    assign out_rd_we = rd_we_q;
    assign out_tag   = tag_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion of the CPU register array: accepts decoded instructions and drives the array's two combinational read-address ports.
- Corrects the returned values with a same-cycle writeback bypass and delivers registered operands to execute over a valid/ready handshake.
- Holds a per-register pending-write scoreboard so that no instruction is issued with a stale source or a colliding destination.
- Sits between decode and execute; its bypass inputs snoop the same writeback signals that drive the register array.

Parameters:
- REG_NUM, 32, number of architectural registers; sets the scoreboard depth.
- REG_WIDTH, 32, operand and data width.
- ADDR_W, 5, register address width (equal to log2 of REG_NUM).
- TAG_W, 32, opaque instruction payload passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  the instruction is accepted this cycle when in_valid is also high.
- in_rs1  in  ADDR_W  source 1 address.
- in_rs2  in  ADDR_W  source 2 address.
- in_rd  in  ADDR_W  destination address.
- in_rd_we  in  1  the instruction will write in_rd.
- in_tag  in  TAG_W  payload.
- reg1_address  out  ADDR_W  to the array; equals in_rs1 combinationally.
- reg2_address  out  ADDR_W  to the array; equals in_rs2 combinationally.
- reg1  in  REG_WIDTH  array read data 1.
- reg2  in  REG_WIDTH  array read data 2.
- wb_word_enable  in  1  snooped writeback, full-word write.
- wb_byte_enable  in  1  snooped writeback, low-byte write.
- wb_address  in  ADDR_W  snooped writeback address.
- wb_data  in  REG_WIDTH  snooped writeback data.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute consumes.
- out_op1  out  REG_WIDTH  source 1 value.
- out_op2  out  REG_WIDTH  source 2 value.
- out_rd  out  ADDR_W  destination address.
- out_rd_we  out  1  destination write flag.
- out_tag  out  TAG_W  payload.
- sb_busy  out  REG_NUM  scoreboard, for debug and visibility.

Behaviour:
- Clock and reset:
  - One clock, clk, rising edge.
  - rst is synchronous and active-high.
  - On reset: out_valid=0; out_op1, out_op2, out_rd, out_rd_we, out_tag all 0; sb_busy all 0. Reset has priority over every other event.
  - Reset mid-operation discards the held output and all pending marks.
- Writeback event: wb_hit = wb_word_enable or wb_byte_enable. When both enables are high, word takes precedence, matching the array.
- Bypass (combinational, per source s):
  - If the array is word-written to rs_s this cycle, the value is wb_data.
  - If it is byte-written, the value is {reg_s[REG_WIDTH-1:8], wb_data[7:0]}.
  - Otherwise the value is reg_s.
  - Register 0 is an ordinary register: no hardwired zero, no special-casing.
- Hazard:
  - A source is blocked if sb_busy[rs_s]=1 and no wb_hit targets rs_s this cycle. A same-cycle writeback clears the block through the bypass.
  - WAW: if in_rd_we=1 and sb_busy[in_rd]=1 with no same-cycle wb_hit to in_rd, the instruction is blocked.
  - Both sources are always checked; there are no per-source valid bits.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard. in_ready may depend combinationally on the in_* fields.
  - Accept = in_valid && in_ready. On accept, the bypassed operands, in_rd, in_rd_we and in_tag are registered.
  - out_valid rises the next cycle: latency is 1 cycle, with full throughput of 1 instruction per cycle when there are no hazards.
  - While out_valid && !out_ready, all out_* fields hold stable.
  - out_valid falls after consumption when no new accept occurs.
- Scoreboard update (per register r, each cycle):
  - Set when an accept has in_rd_we=1 and in_rd=r.
  - Clear when wb_hit and wb_address=r.
  - A simultaneous set and clear of the same r results in set, because the new writer is outstanding.
  - A writeback to a register that is not busy has no scoreboard effect.
- Held operands need no refresh: an accepted source had no pending writer, so its value is final.
- Undefined and not checked: two outstanding writers to one register (prevented by WAW stall), and a writeback to a non-busy register while that register is a source of a held instruction.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_NUM, REG_WIDTH, ADDR_W constants, the same values the register array uses.
  - The typedef reg_addr_t.
  - The typedef reg_data_t.
- Natural sub-module: reg_scoreboard, containing the busy vector, set/clear priority, and the hazard-lookup outputs for rs1, rs2 and rd.
- Bypass muxes and the output register stay in the top.

Test Plan:
- Reset and basic fetch: assert rst and check that all outputs are 0. Then offer rs1=3, rs2=4 with the array holding 0x11 and 0x22 → out_valid next cycle with out_op1=0x11 and out_op2=0x22.
- Word bypass: offer rs1=5 while wb_word_enable=1, wb_address=5, wb_data=0xDEADBEEF, and the array still returns 0x0 → out_op1=0xDEADBEEF.
- Byte bypass: with the array reg2=0x12345678, drive wb_byte_enable=1, wb_address=rs2, wb_data=0xAB → out_op2=0x123456AB.
- RAW stall:
  - Accept rd=7 with we=1 and check sb_busy[7]=1.
  - Offer rs1=7 → in_ready=0 for 3 idle cycles.
  - Drive wb_word_enable, address 7, data 0x99 → accepted that same cycle with out_op1=0x99, and sb_busy[7] returns to 0.
- Backpressure: hold out_ready=0 with out_valid=1 → in_ready=0 and out_* stable for 4 cycles; release → 1 transfer, then the next instruction is accepted.
- Set/clear collision and mid-op reset:
  - With sb_busy[9]=1, accept rd=9 while wb_address=9 → sb_busy[9] stays 1.
  - Assert rst → sb_busy=0 and out_valid=0 next cycle.
